// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: streams N_INPUTS signed (x, w) pairs onto a bias,
// applies ReLU and hands the result downstream. Define SATURATE_EN for clamping accumulation.
module neuron_mac #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int N_INPUTS = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ACC_W-1:0]  bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              busy
);
    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam int P_W   = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        ACTIVATE = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;

    logic [P_W-1:0]     product;
    logic [ACC_W:0]     product_ext;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   acc_step;
    logic               overflow;

    // Sign-extended operands make the truncated unsigned product equal the signed product.
    assign product     = {{DATA_W{x[DATA_W-1]}}, x} * {{DATA_W{w[DATA_W-1]}}, w};
    assign product_ext = {{(ACC_W + 1 - P_W){product[P_W-1]}}, product};
    assign sum_wide    = {acc_q[ACC_W-1], acc_q} + product_ext;
    assign overflow    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

`ifdef SATURATE_EN
    always_comb begin
        acc_step = sum_wide[ACC_W-1:0];
        if (overflow) begin
            acc_step = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign acc_step        = sum_wide[ACC_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = acc_step;
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(N_INPUTS - 1)) begin
                        state_d = ACTIVATE;
                    end
                end
            end
            ACTIVATE: begin
                result_d    = acc_q[ACC_W-1] ? '0 : acc_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac (N_INPUTS=4); expected activations are queued when a run
// starts and popped when the DUT presents its result.
module tb_neuron_mac;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int NI = 4;

    logic          CLK = 1'b0;
    logic          reset, start, in_valid, out_ready;
    logic [AW-1:0] bias;
    logic [DW-1:0] x, w;
    logic          in_ready, out_valid, busy;
    logic [AW-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_q[$];
    logic signed [DW-1:0] xs [NI];
    logic signed [DW-1:0] ws [NI];

    neuron_mac #(.DATA_W(DW), .ACC_W(AW), .N_INPUTS(NI)) dut (
        .CLK(CLK), .reset(reset), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [AW-1:0] model(input logic signed [AW-1:0] b);
        longint a;
        logic [AW-1:0] t;
        a = longint'(b);
        for (int i = 0; i < NI; i++) begin
            a = a + longint'(xs[i]) * longint'(ws[i]);
`ifdef SATURATE_EN
            if (a > 64'sd2147483647) a = 64'sd2147483647;
            if (a < -64'sd2147483648) a = -64'sd2147483648;
`else
            t = a[AW-1:0];
            a = longint'($signed(t));
`endif
        end
        return (a < 0) ? '0 : a[AW-1:0];
    endfunction

    task automatic set_pairs(input int x0, x1, x2, x3, w0, w1, w2, w3);
        xs[0] = DW'(x0); xs[1] = DW'(x1); xs[2] = DW'(x2); xs[3] = DW'(x3);
        ws[0] = DW'(w0); ws[1] = DW'(w1); ws[2] = DW'(w2); ws[3] = DW'(w3);
    endtask

    task automatic drive_start(input logic [AW-1:0] b);
        @(negedge CLK);
        start = 1'b1;
        bias  = b;
        exp_q.push_back(model(b));
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_accum: busy=%b in_ready=%b required 1/1", busy, in_ready);
        end
    endtask

    task automatic send_pair(input int idx, input int gap);
        repeat (gap) @(negedge CLK);
        in_valid = 1'b1;
        x = xs[idx];
        w = ws[idx];
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    // Called on the negedge right after the last pair was accepted.
    task automatic collect(input string name, input int hold, input bit start_at_ack);
        logic [AW-1:0] exp;
        int n;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: out_valid=%b required 0", name, out_valid);
        end
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: out_valid=%b required 1", name, out_valid);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
            void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s_result: result=%h required %h", name, result, exp);
        end
        $display("txn %s: result=%h expected=%h", name, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b1 || result !== exp || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_hold: out_valid=%b result=%h busy=%b required 1/%h/1",
                         name, out_valid, result, exp, busy);
            end
        end
        if (hold > 0) begin
            out_ready = 1'b1;
            if (start_at_ack) start = 1'b1;
        end
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b busy=%b result=%h required 0/0/%h",
                     name, out_valid, busy, result, exp);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (result !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: result=%h out_valid=%b in_ready=%b busy=%b required 0",
                     result, out_valid, in_ready, busy);
        end
    endtask

    task automatic run(input string name, input logic [AW-1:0] b, input int gap, input int hold);
        out_ready = (hold == 0);
        drive_start(b);
        for (int i = 0; i < NI; i++) send_pair(i, gap);
        collect(name, hold, 1'b0);
        out_ready = 1'b1;
    endtask

    task automatic test_basic();
        set_pairs(1, 2, 3, 4, 1, 1, 1, 1);
        run("basic", 32'd0, 0, 0);
    endtask

    task automatic test_negative_relu();
        set_pairs(5, 5, 5, 5, 2, 2, 2, 2);
        run("relu_neg", -32'sd100, 0, 0);
        run("relu_pos", -32'sd10, 0, 0);
    endtask

    task automatic test_backpressure();
        set_pairs(-3, 7, 0, 1, 4, 2, 9, -1);
        run("backpressure", 32'd0, 3, 5);
    endtask

    task automatic test_start_misuse();
        set_pairs(1, 2, 3, 4, 1, 1, 1, 1);
        out_ready = 1'b0;
        drive_start(32'd0);
        send_pair(0, 0);
        start = 1'b1;
        bias  = 32'd999;
        send_pair(1, 0);
        start = 1'b0;
        send_pair(2, 1);
        send_pair(3, 0);
        collect("start_misuse", 1, 1'b1);
        out_ready = 1'b1;
        repeat (4) @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL misuse_restart: out_valid=%b busy=%b required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_reset_midop();
        set_pairs(1, 2, 3, 4, 1, 1, 1, 1);
        drive_start(32'd0);
        send_pair(0, 0);
        send_pair(1, 0);
        #2 reset = 1'b1;
        #1;
        void'(exp_q.pop_back());
        checks++;
        if (result !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: result=%h out_valid=%b in_ready=%b busy=%b required 0",
                     result, out_valid, in_ready, busy);
        end
        @(negedge CLK);
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_partial: out_valid=%b busy=%b required 0/0", out_valid, busy);
        end
        run("after_reset", 32'd0, 0, 0);
    endtask

    task automatic test_overflow();
        set_pairs(32'h7FFF, 3, -5, 9, 32'h7FFF, 0, 0, 0);
        run("overflow", 32'h7FFF0000, 0, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        bias = '0; x = '0; w = '0;
        #12;
        test_reset();
        @(negedge CLK);
        reset = 1'b0;
        test_basic();
        test_negative_relu();
        test_backpressure();
        test_start_misuse();
        test_reset_midop();
        test_overflow();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: size=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
